// File: rtl/posit_extract_es3.sv
// Two-stage decoder from a 32-bit ES=3 posit to the unpacked {sgn, scale, fraction, inf, zero}
// record. Stage 1 classifies the word and measures the regime run; stage 2 builds the fields.
module posit_extract_es3 #(
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          in_posit,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [37:0]          out_value,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NBITS = 32;
    localparam int ES    = 3;

    // ---------------- stage 1 combinational ----------------
    logic              p_zero;
    logic              p_inf;
    logic              p_sgn;
    logic [NBITS-1:0]  p_mag;
    logic [30:0]       run_src;
    logic [4:0]        p_run;
    logic              run_stop;

    assign p_zero  = (in_posit == 32'h0000_0000);
    assign p_inf   = (in_posit == 32'h8000_0000);
    assign p_sgn   = in_posit[31];
    assign p_mag   = p_sgn ? (~in_posit + 32'd1) : in_posit;
    // Fold the regime polarity so the run length becomes a leading-zero count.
    assign run_src = p_mag[30] ? ~p_mag[30:0] : p_mag[30:0];

    always_comb begin
        p_run    = 5'd0;
        run_stop = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (!run_stop) begin
                if (run_src[i]) begin
                    run_stop = 1'b1;
                end else begin
                    p_run = p_run + 5'd1;
                end
            end
        end
    end

    // ---------------- handshake ----------------
    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s2_load;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !reset && (!s1_valid || !s2_valid || out_ready);
    assign out_valid = s2_valid;

    // ---------------- stage 1 registers ----------------
    logic                 s1_sgn;
    logic                 s1_r;
    logic [4:0]           s1_run;
    logic [NBITS-1:0]     s1_mag;
    logic                 s1_zero;
    logic                 s1_inf;
    logic [TAG_WIDTH-1:0] s1_tag;

    // ---------------- stage 2 combinational ----------------
    logic [5:0]       rem_shift;
    logic [NBITS-1:0] rem;
    logic [ES-1:0]    f_exp;
    logic [25:0]      f_frac;
    logic [8:0]       f_k;
    logic [8:0]       f_scale;
    logic [37:0]      f_value;

    // Shifting past sign, run and terminator left-aligns the remaining bits; a shift
    // of 32 or more (run of 30 or 31) correctly yields all zeros.
    assign rem_shift = {1'b0, s1_run} + 6'd2;
    assign rem       = s1_mag << rem_shift;
    assign f_exp     = rem[31:29];
    assign f_frac    = rem[28:3];
    assign f_k       = s1_r ? ({4'b0, s1_run} - 9'd1) : (9'd0 - {4'b0, s1_run});
    assign f_scale   = {f_k[5:0], 3'b000} | {6'b0, f_exp};

    always_comb begin
        f_value = {s1_sgn, f_scale, f_frac, 1'b0, 1'b0};
        if (s1_zero || s1_inf) begin
            f_value = {1'b0, 9'd0, 26'd0, s1_inf, s1_zero};
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sgn    <= 1'b0;
            s1_r      <= 1'b0;
            s1_run    <= '0;
            s1_mag    <= '0;
            s1_zero   <= 1'b0;
            s1_inf    <= 1'b0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            out_value <= '0;
            out_tag   <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_value <= f_value;
                    out_tag   <= s1_tag;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sgn  <= p_sgn;
                    s1_r    <= p_mag[30];
                    s1_run  <= p_run;
                    s1_mag  <= p_mag;
                    s1_zero <= p_zero;
                    s1_inf  <= p_inf;
                    s1_tag  <= in_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_extract_es3.sv
// Bench for posit_extract_es3: directed vector table, random stream against a bit-walking
// reference model, back-pressure ordering and mid-stream reset sequences.
module tb_posit_extract_es3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_posit;
    logic [7:0]  in_tag;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] out_value;
    logic [7:0]  out_tag;
    logic        out_valid;
    logic        out_ready;

    posit_extract_es3 #(.TAG_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_posit(in_posit), .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
        .out_value(out_value), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] pack(input logic sgn, input int scale, input logic [25:0] frac,
                                         input logic inf, input logic zero);
        logic [8:0] s9;
        s9 = scale[8:0];
        return {sgn, s9, frac, inf, zero};
    endfunction

    // Reference: walk the magnitude bit by bit following the posit field definitions.
    function automatic logic [37:0] model(input logic [31:0] p);
        logic [31:0] mag;
        logic        sgn, r;
        int          run, k, pos, ex, sc;
        logic [25:0] frac;
        if (p == 32'h0) return pack(1'b0, 0, 26'd0, 1'b0, 1'b1);
        if (p == 32'h8000_0000) return pack(1'b0, 0, 26'd0, 1'b1, 1'b0);
        sgn = p[31];
        mag = sgn ? (32'd0 - p) : p;
        r = mag[30];
        run = 0;
        pos = 30;
        while (pos >= 0 && mag[pos] == r) begin
            run++;
            pos--;
        end
        k = r ? run - 1 : -run;
        pos = 29 - run;
        ex = 0;
        for (int j = 0; j < 3; j++) begin
            ex = ex * 2 + ((pos >= 0) ? int'(mag[pos]) : 0);
            pos--;
        end
        frac = '0;
        for (int j = 25; j >= 0; j--) begin
            frac[j] = (pos >= 0) ? mag[pos] : 1'b0;
            pos--;
        end
        sc = 8 * k + ex;
        return pack(sgn, sc, frac, 1'b0, 1'b0);
    endfunction

    typedef struct {
        logic [31:0] p;
        logic [7:0]  tag;
    } op_t;

    typedef struct {
        logic [31:0] p;
        logic [37:0] exp;
    } vec_t;

    op_t         sbq[$];
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [45:0] held;

    task automatic monitor();
        op_t item;
        if (reset) begin
            sbq.delete();
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) check("hold_stable", {18'd0, out_tag, out_value}, {18'd0, held});
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_output", 64'd1, 64'd0);
            end else begin
                item = sbq.pop_front();
                check("rand_value", {26'd0, out_value}, {26'd0, model(item.p)});
                check("rand_tag", {56'd0, out_tag}, {56'd0, item.tag});
            end
        end
        prev_stall = out_valid && !out_ready;
        held = {out_tag, out_value};
        if (in_valid && in_ready) sbq.push_back('{in_posit, in_tag});
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_posit();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h8000_0001;
            5: return $urandom >> $urandom_range(0, 31);
            6: return ~($urandom >> $urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    vec_t        vecs[11];
    logic [7:0]  got[$];
    int          gcyc[$];
    int          idx, acc, n, budget;
    bit          a;

    initial begin
        vecs[0]  = '{32'h4000_0000, pack(1'b0, 0, 26'd0, 1'b0, 1'b0)};
        vecs[1]  = '{32'h0000_0000, pack(1'b0, 0, 26'd0, 1'b0, 1'b1)};
        vecs[2]  = '{32'h8000_0000, pack(1'b0, 0, 26'd0, 1'b1, 1'b0)};
        vecs[3]  = '{32'h4800_0000, pack(1'b0, 2, 26'd0, 1'b0, 1'b0)};
        vecs[4]  = '{32'h4010_0000, pack(1'b0, 0, 26'h010_0000, 1'b0, 1'b0)};
        vecs[5]  = '{32'hC000_0000, pack(1'b1, 0, 26'd0, 1'b0, 1'b0)};
        vecs[6]  = '{32'h7FFF_FFFF, pack(1'b0, 240, 26'd0, 1'b0, 1'b0)};
        vecs[7]  = '{32'h0000_0001, pack(1'b0, -240, 26'd0, 1'b0, 1'b0)};
        vecs[8]  = '{32'hFFFF_FFFF, pack(1'b1, -240, 26'd0, 1'b0, 1'b0)};
        vecs[9]  = '{32'h3FFF_FFFF, pack(1'b0, -1, 26'h3FF_FFFF, 1'b0, 1'b0)};
        vecs[10] = '{32'h6000_0000, pack(1'b0, 8, 26'd0, 1'b0, 1'b0)};

        reset = 1'b1; in_posit = '0; in_tag = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_value", {26'd0, out_value}, 64'd0);
        check("reset_out_tag", {56'd0, out_tag}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_empty", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Directed table, one operand at a time, checking the two-cycle latency.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_posit = vecs[i].p; in_tag = 8'(i + 16);
            @(negedge clk);
            check("vec_in_ready", {63'd0, in_ready}, 64'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("vec_latency_early", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("vec_latency_valid", {63'd0, out_valid}, 64'd1);
            check("vec_value", {26'd0, out_value}, {26'd0, vecs[i].exp});
            check("vec_tag", {56'd0, out_tag}, 64'(i + 16));
            @(posedge clk); #1;
        end

        // Back-pressure: tags 1..6 with the output stalled for five cycles.
        out_ready = 1'b0; idx = 1; acc = 0;
        repeat (5) begin
            in_valid = 1'b1; in_tag = 8'(idx); in_posit = rand_posit();
            @(negedge clk);
            a = in_valid && in_ready;
            @(posedge clk); #1;
            if (a) begin idx++; acc++; end
        end
        @(negedge clk);
        check("stall_accepts", 64'(acc), 64'd2);
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_out_tag", {56'd0, out_tag}, 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1; n = 0;
        while (n < 40 && got.size() < 6) begin
            in_valid = (idx <= 6); in_tag = 8'(idx); in_posit = rand_posit();
            @(negedge clk);
            if (out_valid) begin got.push_back(out_tag); gcyc.push_back(n); end
            a = in_valid && in_ready;
            @(posedge clk); #1;
            if (a) idx++;
            n++;
        end
        in_valid = 1'b0;
        check("stream_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size(); i++) begin
            check("stream_order", {56'd0, got[i]}, 64'(i + 1));
            check("stream_rate", 64'(gcyc[i] - gcyc[0]), 64'(i));
        end
        repeat (3) tick();

        // Random traffic against the reference model.
        mon_en = 1'b1;
        repeat (600) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_posit = rand_posit();
            in_tag = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        check("drain_empty", 64'(sbq.size()), 64'd0);
        mon_en = 1'b0;

        // Mid-stream reset with two operands in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_posit = 32'h4000_0000; in_tag = 8'hA1;
        @(posedge clk); #1;
        in_tag = 8'hA2; in_posit = 32'hC000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("inflight_full", {62'd0, out_valid, in_ready}, 64'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_pulse_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_pulse_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_posit = 32'h4800_0000; in_tag = 8'hB1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        budget = 0;
        @(negedge clk);
        while (!out_valid && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("post_reset_timeout", {63'd0, out_valid}, 64'd1);
        check("post_reset_tag", {56'd0, out_tag}, 64'hB1);
        check("post_reset_value", {26'd0, out_value}, {26'd0, pack(1'b0, 2, 26'd0, 1'b0, 1'b0)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
